// File: rtl/raw_word_collector.sv
// raw_word_collector: deserializes a raw entropy bit stream into words for the corrector, holding off after each issue
module raw_word_collector #(
  parameter int INPUT_WIDTH = 10,
  parameter int M_WIDTH = 3,
  parameter int HOLD_CYCLES = 2 ** M_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  input  logic                   clr_ovf,
  output logic [INPUT_WIDTH-1:0] word_out,
  output logic                   start,
  output logic                   busy,
  output logic                   overflow
);
  localparam int CW = $clog2(INPUT_WIDTH + 1);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  typedef enum logic [1:0] {FILL, ISSUE, HOLD} state_t;
  state_t state_q, state_d;
  logic [INPUT_WIDTH-1:0] shreg_q, shreg_d, word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic ovf_q, ovf_d, full, xfer, accept, drop;
  // next state: bits accumulate in any state; a full word moves to word_out only from FILL
  always_comb begin
    full = cnt_q == CW'(INPUT_WIDTH);
    xfer = state_q == FILL && full;
    accept = bit_valid && !full;
    drop = bit_valid && full && !xfer;
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d = cnt_q;
    hold_d = hold_q;
    word_d = word_q;
    ovf_d = drop | (ovf_q & ~clr_ovf);
    if (accept) begin
      shreg_d = {shreg_q[INPUT_WIDTH-2:0], bit_in};
      cnt_d = cnt_q + 1'b1;
    end
    if (xfer) begin
      word_d = shreg_q;
      state_d = ISSUE;
      cnt_d = bit_valid ? CW'(1) : '0;
      shreg_d = bit_valid ? {{(INPUT_WIDTH-1){1'b0}}, bit_in} : shreg_q;
    end
    if (state_q == ISSUE) begin
      state_d = HOLD;
      hold_d = HW'(HOLD_CYCLES - 1);
    end
    if (state_q == HOLD) begin
      state_d = hold_q == '0 ? FILL : HOLD;
      hold_d = hold_q == '0 ? hold_q : hold_q - 1'b1;
    end
  end
  // state registers; reset discards any partial word immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      shreg_q <= '0;
      cnt_q <= '0;
      hold_q <= '0;
      word_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      word_q <= word_d;
      ovf_q <= ovf_d;
    end
  end
  assign word_out = word_q;
  assign start = state_q == ISSUE;
  assign busy = state_q != FILL;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_raw_word_collector.sv
// tb_raw_word_collector: directed checks of word assembly, issue timing, hold-off and overflow
module tb_raw_word_collector;
  logic clk = 1'b0, rst = 1'b1, bit_in = 1'b0, bv = 1'b0, sel = 1'b0, clr = 1'b0;
  logic v1, v2, s1, s2, b1, b2, o1, o2;
  logic [9:0] w1, w2;
  int checks = 0, errors = 0, nb, ns, nw;
  logic [9:0] pa = 10'b1011001011, pb = 10'b0011110000, pe = 10'h155;
  logic [49:0] sc = 50'h3_1A2B_3C4D_5E6F;
  logic [19:0] gd = 20'hA5C3F;
  logic [23:0] sf = 24'hC3A596;
  assign v1 = bv & ~sel;
  assign v2 = bv & sel;
  always #5 clk = ~clk;
  raw_word_collector dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(v1), .clr_ovf(clr),
    .word_out(w1), .start(s1), .busy(b1), .overflow(o1)
  );
  raw_word_collector #(.HOLD_CYCLES(12)) dut_h12 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(v2), .clr_ovf(clr),
    .word_out(w2), .start(s2), .busy(b2), .overflow(o2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask
  task automatic tick(input logic v, input logic b, input logic c);
    bv = v;
    bit_in = b;
    clr = c;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    chk("rst_word", w1, 0);
    chk("rst_start", s1, 0);
    chk("rst_busy", b1, 0);
    chk("rst_ovf", o1, 0);
    chk("rst_word_h12", w2, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick(1'b1, pa[9-i], 1'b0);
    chk("a_nostart", s1, 0);
    chk("a_nobusy", b1, 0);
    tick(1'b0, 1'b0, 1'b0);
    chk("a_start", s1, 1);
    chk("a_busy", b1, 1);
    chk("a_word", w1, 10'h2CB);
    nb = 1;
    ns = 0;
    repeat (20) begin
      tick(1'b0, 1'b0, 1'b0);
      nb += int'(b1);
      ns += int'(s1);
    end
    chk("a_busy_len", nb, 9);
    chk("a_extra_start", ns, 0);
    chk("a_ovf", o1, 0);
    chk("a_word_hold", w1, 10'h2CB);
    repeat (5) tick(1'b1, 1'b1, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("b_word", w1, 0);
    chk("b_start", s1, 0);
    chk("b_busy", b1, 0);
    chk("b_ovf", o1, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ns = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, pb[9-i], 1'b0);
      ns += int'(s1);
    end
    chk("b_no_stale_start", ns, 0);
    tick(1'b0, 1'b0, 1'b0);
    chk("b_fresh_start", s1, 1);
    chk("b_fresh_word", w1, 10'h0F0);
    #2;
    rst = 1'b1;
    #1;
    chk("b_rst_issue_start", s1, 0);
    chk("b_rst_issue_busy", b1, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    nw = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1'b1, sc[49-i], 1'b0);
      chk("c_start", s1, 32'(i % 10 == 0 && i != 0));
      if (s1) begin
        chk("c_word", w1, sc[49-10*nw -: 10]);
        nw++;
      end
    end
    tick(1'b0, 1'b0, 1'b0);
    chk("c_start_last", s1, 1);
    chk("c_word_last", w1, sc[9:0]);
    chk("c_count", nw, 4);
    chk("c_ovf", o1, 0);
    repeat (10) tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) tick(1'b1, gd[19-i/2], 1'b0);
      else tick(1'b0, 1'b1, 1'b0);
      chk("d_start", s1, 32'(i == 19 || i == 39));
      if (i == 19) chk("d_word0", w1, gd[19:10]);
      if (i == 30) chk("d_stable", w1, gd[19:10]);
      if (i == 39) chk("d_word1", w1, gd[9:0]);
    end
    chk("d_ovf", o1, 0);
    repeat (10) tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b1, pe[9-i], 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    chk("e_start", s1, 1);
    chk("e_word", w1, 10'h155);
    chk("e_ovf", o1, 0);
    repeat (9) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("e_start2", s1, 1);
    chk("e_word2", w1, 10'h200);
    chk("e_ovf2", o1, 0);
    repeat (10) tick(1'b0, 1'b0, 1'b0);
    sel = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, sf[23-i], 1'b0);
      chk("f_start", s2, 32'(i == 10));
      chk("f_ovf_clean", o2, 0);
      if (i == 10) chk("f_word0", w2, sf[23:14]);
    end
    tick(1'b1, sf[3], 1'b0);
    chk("f_ovf_set", o2, 1);
    tick(1'b1, sf[2], 1'b1);
    chk("f_ovf_set_wins", o2, 1);
    tick(1'b0, 1'b0, 1'b1);
    chk("f_ovf_clr", o2, 0);
    tick(1'b1, 1'b1, 1'b0);
    chk("f_ovf_again", o2, 1);
    chk("f_fill", b2, 0);
    tick(1'b0, 1'b0, 1'b0);
    chk("f_start2", s2, 1);
    chk("f_word1", w2, sf[13:4]);
    chk("f_ovf_kept", o2, 1);
    tick(1'b0, 1'b0, 1'b1);
    chk("f_ovf_clr2", o2, 0);
    chk("f_dut1_ovf", o1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/raw_word_collector.md
Name: raw_word_collector

Overview:
Front-end feeder for the non-linear corrector datapath. It deserializes a raw single-bit entropy stream into INPUT_WIDTH-bit words. Each completed word is presented on word_out with a one-cycle start pulse. It then holds off for HOLD_CYCLES cycles so the downstream down-counter can finish before the next word. Bits keep accumulating during hold-off; bits that cannot be stored are dropped and flagged.

Parameters:
INPUT_WIDTH, 10, width of the assembled word; must match the corrector's `in` width; >= 2
M_WIDTH, 3, width of the corrector's y field; used only for the default hold length
HOLD_CYCLES, 8 (2**M_WIDTH), cycles spent in HOLD after each issue; >= 1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
bit_in  input  1  raw entropy bit
bit_valid  input  1  bit_in is sampled on this rising edge when high
clr_ovf  input  1  synchronous clear of overflow
word_out  output  INPUT_WIDTH  assembled word to the corrector's `in`; stable between issues
start  output  1  one-cycle pulse, word_out newly valid; drives the corrector's start
busy  output  1  high in ISSUE or HOLD
overflow  output  1  sticky, at least one bit was dropped

Behaviour:
- Reset (async, immediate): state=FILL, shreg=0, cnt=0, hold_cnt=0, word_out=0, start=0, busy=0, overflow=0. Reset mid-word discards any partial bits. Reset during ISSUE drops start in the same cycle.
- Shift register shreg[INPUT_WIDTH-1:0], bit counter cnt (0..INPUT_WIDTH).
- Accepted bit: shreg <= {shreg[W-2:0], bit_in}; cnt <= cnt+1. The first bit of a word ends at the MSB, which is the corrector's y MSB.
- A bit is accepted when bit_valid=1 and cnt<W, in any state.
- When bit_valid=1 and cnt==W in ISSUE/HOLD, or in FILL on a non-transfer edge: the bit is dropped and overflow<=1.
- overflow: a set and a clr_ovf on the same edge leaves overflow=1 (set wins). Otherwise clr_ovf clears it.
- States:
  - FILL:
    - If cnt==W: transfer edge.
      - word_out<=shreg; state<=ISSUE.
      - cnt<=0, or cnt<=1 with shreg<=bit_in if bit_valid on this edge. That bit is the first bit of the next word, not dropped.
    - Otherwise: accept bits, stay in FILL.
  - ISSUE (exactly 1 cycle): start=1, busy=1. Next edge: hold_cnt<=HOLD_CYCLES-1, state<=HOLD.
  - HOLD (exactly HOLD_CYCLES cycles): busy=1, start=0. If hold_cnt==0, state<=FILL; else decrement hold_cnt.
- start and busy are decoded from the registered state (glitch-free, no combinational path from inputs).
- Latency: the edge that accepts the W-th bit is edge k. Transfer happens at edge k+1. start is high from edge k+1 to edge k+2.
- Throughput: one word per W cycles at a continuous bit rate when HOLD_CYCLES <= W-2, with no drops. Minimum issue spacing is HOLD_CYCLES+2 cycles.
- A word completed during HOLD waits with cnt==W. It transfers on the first FILL edge.
- word_out changes only on transfer edges.
- Counter widths: cnt uses $clog2(INPUT_WIDTH+1) bits; hold_cnt uses max(1,$clog2(HOLD_CYCLES)) bits. Neither counter ever wraps.

Test Plan:
- Reset: assert rst asynchronously mid-word (cnt=5) -> all outputs 0 immediately. After release, the next 10 bits form a fresh word (no stale bits).
- Single word, defaults: bits 1,0,1,1,0,0,1,0,1,1 with bit_valid=1 on consecutive edges, then idle -> start pulses once, one edge after the 10th bit. word_out=10'b1011001011 (0x2CB). busy high for 9 cycles (ISSUE + 8 HOLD). overflow=0.
- Continuous stream, defaults: bit_valid=1 every cycle for 50 cycles -> start pulses every 10 cycles. Each word equals the 10 bits in arrival order, first bit at MSB. overflow stays 0.
- Overflow, HOLD_CYCLES=12, continuous bits -> overflow sets on the 11th bit arriving in HOLD. The dropped bits are absent from the next word_out. clr_ovf=1 with no new drop clears it. clr_ovf coincident with a drop keeps overflow=1.
- Gapped bits: bit_valid toggles 1/0 -> word_out is unaffected by invalid cycles. start spacing is 20 cycles. word_out is stable between pulses.
- Transfer-edge bit: 10th bit at edge k, another bit at k+1 -> that bit becomes the MSB of the following word and is not counted as dropped.
